// File: rtl/s_frame_packer.sv
// Packs OSR(N) consecutive CBADC control words into {rs1, rs2} frames and buffers them in a FWFT FIFO.
// Define S_FRAME_PACKER_DROP_OLDEST_EN to make a push into a full FIFO evict the head instead of the new frame.
module s_frame_packer #(
  parameter int N          = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                enable,
  input  logic                                s_valid,
  input  logic [N-1:0]                        s_in,
  output logic                                frame_valid,
  output logic [31:0]                         frame_rs1,
  output logic [31:0]                         frame_rs2,
  input  logic                                frame_pop,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fill_level,
  output logic                                overflow,
  input  logic                                clear_ovf
);

  function automatic int osr_f(input int n);
    case (n)
      3:       return 32'sd20;
      4:       return 32'sd15;
      5:       return 32'sd12;
      6:       return 32'sd9;
      7:       return 32'sd8;
      8:       return 32'sd7;
      default: return 32'sd1;
    endcase
  endfunction

  function automatic int r1_f(input int n);
    case (n)
      3:       return 32'sd10;
      4:       return 32'sd7;
      5:       return 32'sd6;
      6:       return 32'sd4;
      7:       return 32'sd4;
      8:       return 32'sd3;
      default: return 32'sd1;
    endcase
  endfunction

  localparam int OSR = osr_f(N);
  localparam int R1  = r1_f(N);
  localparam int WW  = OSR * N;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  if ((N < 3) || (N > 8)) begin : g_bad_n
    $error("s_frame_packer: N must be in 3..8");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("s_frame_packer: FIFO_DEPTH must be a power of two, at least 2");
  end

  logic [4:0]    cnt_q, cnt_d;
  logic [WW-1:0] words_q, words_d;
  logic [WW-1:0] frame_words_s;
  logic          accept_s;
  logic          push_s;
  logic [63:0]   new_frame_s;

  logic [63:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          valid_q, valid_d;
  logic [63:0]   head_q, head_d;
  logic          pop_s, full_s, ovf_event_s, do_write_s, rd_adv_s;

  // Word capture: slot the incoming word into the partial frame and detect frame completion.
  always_comb begin
    accept_s      = enable && s_valid;
    frame_words_s = words_q;
    for (int j = 0; j < OSR; j++) begin
      frame_words_s[j*N +: N] = (accept_s && (cnt_q == 5'(j))) ? s_in : words_q[j*N +: N];
    end
    push_s      = accept_s && (cnt_q == 5'(OSR - 1));
    // rs1 holds the oldest R1 words, rs2 the rest; zero-extension keeps unused upper bits at 0.
    new_frame_s = {32'(frame_words_s[WW-1:R1*N]), 32'(frame_words_s[R1*N-1:0])};
    cnt_d       = cnt_q;
    words_d     = words_q;
    if (!enable) begin
      cnt_d   = '0;
      words_d = '0;
    end else if (push_s) begin
      cnt_d   = '0;
      words_d = '0;
    end else if (accept_s) begin
      cnt_d   = cnt_q + 5'd1;
      words_d = frame_words_s;
    end else begin
      cnt_d   = cnt_q;
      words_d = words_q;
    end
  end

  // FIFO control: pointers, occupancy, overflow flag and the registered head frame.
  always_comb begin
    pop_s       = frame_pop && (count_q != '0);
    full_s      = (count_q == CW'(FIFO_DEPTH));
    ovf_event_s = push_s && full_s && !pop_s;
`ifdef S_FRAME_PACKER_DROP_OLDEST_EN
    do_write_s  = push_s;
    rd_adv_s    = pop_s || ovf_event_s;
`else
    do_write_s  = push_s && !ovf_event_s;
    rd_adv_s    = pop_s;
`endif
    wr_ptr_d = do_write_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = rd_adv_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({do_write_s, rd_adv_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (ovf_event_s) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    valid_d = (count_d != '0);
    // The slot being written this edge can itself become the head (push into an empty FIFO).
    if (count_d == '0) begin
      head_d = '0;
    end else if (do_write_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = new_frame_s;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // State registers for capture and FIFO control.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q    <= '0;
      words_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      words_q  <= words_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  // Frame storage array.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_write_s) begin
      mem_q[wr_ptr_q] <= new_frame_s;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  assign frame_valid = valid_q;
  assign frame_rs1   = head_q[31:0];
  assign frame_rs2   = head_q[63:32];
  assign fill_level  = count_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_s_frame_packer.sv
// Directed bench for s_frame_packer: an N=8 instance for table vectors and FIFO corners, an N=4 instance for layout/throughput.
module tb_s_frame_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        en, sv, pop, clr;
  logic [7:0]  din;
  logic        fv, ovf;
  logic [31:0] rs1, rs2;
  logic [2:0]  fill;

  logic        en4, sv4, pop4;
  logic [3:0]  din4;
  logic        fv4, ovf4;
  logic [31:0] r41, r42;
  logic [2:0]  fill4;

  int pass_cnt  = 0;
  int total_cnt = 0;

`ifdef S_FRAME_PACKER_DROP_OLDEST_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  s_frame_packer #(.N(8), .FIFO_DEPTH(4)) u8 (
    .clk(clk), .resetn(resetn), .enable(en), .s_valid(sv), .s_in(din),
    .frame_valid(fv), .frame_rs1(rs1), .frame_rs2(rs2), .frame_pop(pop),
    .fill_level(fill), .overflow(ovf), .clear_ovf(clr)
  );

  s_frame_packer #(.N(4), .FIFO_DEPTH(4)) u4 (
    .clk(clk), .resetn(resetn), .enable(en4), .s_valid(sv4), .s_in(din4),
    .frame_valid(fv4), .frame_rs1(r41), .frame_rs2(r42), .frame_pop(pop4),
    .fill_level(fill4), .overflow(ovf4), .clear_ovf(1'b0)
  );

  typedef struct {
    logic        en, sv;
    logic [7:0]  din;
    logic        pop, clr;
    logic        ev;
    logic [31:0] e1, e2;
    logic [2:0]  ef;
    logic        eo;
  } vec_t;

  vec_t vq[$];

  function automatic void addv(input logic e, input logic s, input logic [7:0] d, input logic p,
                               input logic ev, input logic [31:0] e1, input logic [31:0] e2,
                               input logic [2:0] ef);
    vec_t v;
    v.en = e; v.sv = s; v.din = d; v.pop = p; v.clr = 1'b0;
    v.ev = ev; v.e1 = e1; v.e2 = e2; v.ef = ef; v.eo = 1'b0;
    vq.push_back(v);
  endfunction

  function automatic logic [31:0] f1(input logic [7:0] b);
    return {8'h00, b + 8'd2, b + 8'd1, b};
  endfunction

  function automatic logic [31:0] f2(input logic [7:0] b);
    return {b + 8'd6, b + 8'd5, b + 8'd4, b + 8'd3};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string name, input logic ev, input logic [31:0] e1,
                        input logic [31:0] e2, input logic [2:0] ef, input logic eo);
    total_cnt++;
    if ({fv, rs1, rs2, fill, ovf} === {ev, e1, e2, ef, eo}) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got valid=%0b rs1=%h rs2=%h fill=%0d ovf=%0b, want valid=%0b rs1=%h rs2=%h fill=%0d ovf=%0b",
               name, fv, rs1, rs2, fill, ovf, ev, e1, e2, ef, eo);
    end
  endtask

  task automatic check4(input string name, input logic ev, input logic [31:0] e1,
                        input logic [31:0] e2, input logic [2:0] ef);
    total_cnt++;
    if ({fv4, r41, r42, fill4, ovf4} === {ev, e1, e2, ef, 1'b0}) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got valid=%0b rs1=%h rs2=%h fill=%0d ovf=%0b, want valid=%0b rs1=%h rs2=%h fill=%0d ovf=0",
               name, fv4, r41, r42, fill4, ovf4, ev, e1, e2, ef);
    end
  endtask

  task automatic feed_frame(input logic [7:0] b, input logic pl, input logic cl);
    for (int i = 0; i < 7; i++) begin
      en  = 1'b1;
      sv  = 1'b1;
      din = b + 8'(i);
      pop = (i == 6) ? pl : 1'b0;
      clr = (i == 6) ? cl : 1'b0;
      step();
    end
    sv  = 1'b0;
    din = 8'h00;
    pop = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    logic [7:0] h5, h6, h7;
    logic [7:0] drain [3];

    resetn = 1'b0;
    en = 1'b0; sv = 1'b0; din = 8'h00; pop = 1'b0; clr = 1'b0;
    en4 = 1'b0; sv4 = 1'b0; din4 = 4'h0; pop4 = 1'b0;

    // Vector table: words 1..7, hold, pop, pop while empty, then enable-drop of a partial frame.
    for (int i = 0; i < 6; i++) addv(1'b1, 1'b1, 8'(i + 1), 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    addv(1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 32'h00030201, 32'h07060504, 3'd1);
    addv(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 32'h00030201, 32'h07060504, 3'd1);
    addv(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0, 3'd0);
    addv(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0, 3'd0);
    for (int i = 0; i < 5; i++) addv(1'b1, 1'b1, 8'(8'hA1 + i), 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    addv(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    for (int i = 0; i < 6; i++) addv(1'b1, 1'b1, 8'(8'h11 + i), 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    addv(1'b1, 1'b1, 8'h17, 1'b0, 1'b1, 32'h00131211, 32'h17161514, 3'd1);
    addv(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0, 3'd0);

    step();
    step();
    check8("reset_state", 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    @(negedge clk);
    resetn = 1'b1;

    foreach (vq[i]) begin
      en = vq[i].en; sv = vq[i].sv; din = vq[i].din; pop = vq[i].pop; clr = vq[i].clr;
      step();
      check8($sformatf("vec%0d", i), vq[i].ev, vq[i].e1, vq[i].e2, vq[i].ef, vq[i].eo);
    end
    sv = 1'b0; pop = 1'b0;

    // Fill the FIFO, then overflow, clear, push+pop while full, loss with clear in the same cycle.
    for (int k = 1; k <= 4; k++) begin
      feed_frame(8'(k * 16), 1'b0, 1'b0);
      check8($sformatf("fill%0d", k), 1'b1, f1(8'h10), f2(8'h10), 3'(k), 1'b0);
    end
    h5 = DROP ? 8'h20 : 8'h10;
    h6 = DROP ? 8'h30 : 8'h20;
    h7 = DROP ? 8'h40 : 8'h20;
    feed_frame(8'h50, 1'b0, 1'b0);
    check8("overflow", 1'b1, f1(h5), f2(h5), 3'd4, 1'b1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check8("clear_ovf", 1'b1, f1(h5), f2(h5), 3'd4, 1'b0);
    feed_frame(8'h60, 1'b1, 1'b0);
    check8("full_push_pop", 1'b1, f1(h6), f2(h6), 3'd4, 1'b0);
    feed_frame(8'h70, 1'b0, 1'b1);
    check8("set_wins", 1'b1, f1(h7), f2(h7), 3'd4, 1'b1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check8("clear_ovf2", 1'b1, f1(h7), f2(h7), 3'd4, 1'b0);
    if (DROP) begin
      drain[0] = 8'h50; drain[1] = 8'h60; drain[2] = 8'h70;
    end else begin
      drain[0] = 8'h30; drain[1] = 8'h40; drain[2] = 8'h60;
    end
    for (int k = 0; k < 3; k++) begin
      pop = 1'b1;
      step();
      check8($sformatf("drain%0d", k), 1'b1, f1(drain[k]), f2(drain[k]), 3'(3 - k), 1'b0);
    end
    step();
    check8("drain_last", 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    step();
    check8("pop_empty", 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    pop = 1'b0;

    // Asynchronous reset with two frames stored and three words pending.
    feed_frame(8'h80, 1'b0, 1'b0);
    feed_frame(8'h90, 1'b0, 1'b0);
    check8("pre_reset", 1'b1, f1(8'h80), f2(8'h80), 3'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      en = 1'b1; sv = 1'b1; din = 8'(8'hC0 + i);
      step();
    end
    sv = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check8("async_reset", 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    feed_frame(8'h31, 1'b0, 1'b0);
    check8("post_reset_frame", 1'b1, 32'h00333231, 32'h37363534, 3'd1, 1'b0);

    // N=4: layout and one frame per 15 cycles with no gap at the wrap.
    for (int j = 0; j < 30; j++) begin
      en4 = 1'b1;
      sv4 = 1'b1;
      din4 = (j < 15) ? 4'(j) : 4'(30 - j);
      step();
      if (j == 13) check4("n4_pre", 1'b0, 32'h0, 32'h0, 3'd0);
      if (j == 14) check4("n4_frame1", 1'b1, 32'h06543210, 32'hEDCBA987, 3'd1);
      if (j == 15) check4("n4_nodead", 1'b1, 32'h06543210, 32'hEDCBA987, 3'd1);
      if (j == 28) check4("n4_pre2", 1'b1, 32'h06543210, 32'hEDCBA987, 3'd1);
      if (j == 29) check4("n4_frame2", 1'b1, 32'h06543210, 32'hEDCBA987, 3'd2);
    end
    en4 = 1'b0; sv4 = 1'b0;
    pop4 = 1'b1;
    step();
    pop4 = 1'b0;
    check4("n4_pop", 1'b1, 32'h09ABCDEF, 32'h12345678, 3'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/s_frame_packer.md
# s_frame_packer

Upstream feeder for the FIR accelerator. It captures one N-bit digital-control word per clock from the CBADC modulator interface. It groups each run of OSR(N) consecutive words into one two-register frame {rs1, rs2}, packed in exactly the bit layout the accelerator's S-shift/calculate instruction unpacks. Frames are buffered in a first-word-fall-through FIFO until the CPU pops them to issue as PCPI operands.

## Interface
Parameters:
- N, 8, number of analog states / control-word width; legal 3..8, any other value is an elaboration error
- FIFO_DEPTH, 4, number of frames buffered; power of two, minimum 2

Ports:
- clk  input  1  clock
- resetn  input  1  reset, asynchronous, active-low
- enable  input  1  capture enable; low discards any partial frame
- s_valid  input  1  s_in carries a new control word this cycle
- s_in  input  N  control word from the modulator
- frame_valid  output  1  FIFO not empty; head frame presented
- frame_rs1  output  32  head frame, rs1 operand
- frame_rs2  output  32  head frame, rs2 operand
- frame_pop  input  1  consume head frame
- fill_level  output  $clog2(FIFO_DEPTH+1)  frames currently stored
- overflow  output  1  sticky, set when a frame is lost
- clear_ovf  input  1  clears overflow

## Operation
- OSR(N) and the split between the two registers are fixed per N (R1 words in rs1, R2 words in rs2):
  - N=3: OSR 20, split 10/10
  - N=4: OSR 15, split 7/8
  - N=5: OSR 12, split 6/6
  - N=6: OSR 9, split 4/5
  - N=7: OSR 8, split 4/4
  - N=8: OSR 7, split 3/4
- Word j of a frame (j=0 oldest, j=OSR-1 newest) is placed as follows:
  - j<R1: rs1[(j+1)*N-1 : j*N]
  - j>=R1: rs2[(j-R1+1)*N-1 : (j-R1)*N]
- All unused upper bits of rs1 and rs2 are 0.
- A word counter runs 0..OSR-1. It advances on each clk with enable && s_valid and wraps to 0 after the OSR-th word.
- Frame push: on the edge accepting word OSR-1, the complete frame (stored words plus the current s_in) is written to the FIFO on that same edge.
- enable low: counter and partial-frame storage are cleared on the next edge, and s_valid is ignored. FIFO contents are unaffected.
- Pop: frame_pop && frame_valid removes the head frame. A pop while empty is ignored with no state change.
- Simultaneous push and pop: both take effect; fill_level is unchanged. This also holds when the FIFO is full, and no overflow is raised.
- Push while full without a pop: overflow goes to 1 and a frame is lost. Which frame is lost depends on the configuration below.
- overflow clear: clear_ovf clears the flag. If a loss occurs in the same cycle as clear_ovf, set wins.

## Timing
- Reset values:
  - frame_valid=0
  - frame_rs1=0, frame_rs2=0
  - fill_level=0
  - overflow=0
  - counter=0 and FIFO pointers=0
- frame_valid rises on the edge that pushes the first frame, one cycle after the last word is presented on s_in.
- frame_rs1 and frame_rs2 are registered-head outputs. They are stable while frame_valid=1 and frame_pop=0.
- After a pop, the next frame is visible the following cycle with no bubble.
- Back-to-back frames: sustained throughput is 1 word/clk. A frame is produced every OSR cycles with no dead cycle at the wrap.
- Reset asserted mid-frame or with the FIFO non-empty: all state clears immediately and the partial frame is discarded.

## Configuration
- S_FRAME_PACKER_DROP_OLDEST_EN defined: when a push meets a full FIFO, the head frame is discarded and the new frame is written. The FIFO always holds the newest FIFO_DEPTH frames.
- S_FRAME_PACKER_DROP_OLDEST_EN undefined (default): the new frame is discarded and the FIFO contents are untouched.
- In both cases overflow is set and fill_level stays at FIFO_DEPTH.

## Test plan
- N=8, enable=1, words 0x01..0x07 on consecutive cycles:
  - frame_valid=1 the cycle after 0x07
  - frame_rs1=0x00030201, frame_rs2=0x07060504
- N=4, words 0x0..0xE:
  - frame_rs1=0x06543210, frame_rs2=0xEDCBA987
  - a continuous stream produces a new frame every 15 cycles
- N=8, 5 words, then enable=0 for one cycle, then words 0x11..0x17:
  - first frame is rs1=0x00131211, rs2=0x17161514
  - the partial frame is discarded
- FIFO_DEPTH=4, push 5 frames (tagged by first word 1..5) without popping:
  - overflow=1, fill_level=4
  - macro undefined: head is frame 1
  - macro defined: head is frame 2
- FIFO full, frame_pop=1 in the same cycle as a push:
  - fill_level stays 4, overflow stays 0, next head is frame 2
- resetn pulsed low with 2 frames stored and 3 words pending:
  - all outputs return to reset values
  - the next 7 words (N=8) form a clean frame
